// File: rtl/rsbus_slot_scheduler_pkg.sv
// Ring bus types and slot-scheduler constants shared by the scheduler and its picker.
package rsbus_slot_scheduler_pkg;

   localparam int unsigned RSBUS_SHORT_WORDS = 2;
   localparam int unsigned RSBUS_LONG_WORDS  = 10;

   typedef logic [1:0] rsbus_pri_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] tag;
   } rbus_ctrl_t;

   // The five header control bits sit at the top of the word.
   typedef struct packed {
      logic        frm_used;
      logic        frm_owned;
      rsbus_pri_t  frm_priority;
      logic        frm_len;
      logic [26:0] payload;
   } rbus_hdr_t;

   typedef union packed {
      rbus_hdr_t   header;
      logic [31:0] raw;
   } rbus_word_t;

   localparam int unsigned RSBUS_HDR_CTRL_W = 5;

   typedef enum logic [1:0] {
      ST_PASS,
      ST_FILL,
      ST_PAD
   } sched_state_t;

endpackage

// File: rtl/rsbus_slot_scheduler_rr_pri_picker.sv
// Priority picker: highest priority among eligible requesters, ties broken
// round-robin starting at rr_ptr.
module rsbus_rr_pri_picker
   import rsbus_slot_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0]   elig,
   input  logic [N_REQ*2-1:0] pri,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [N_REQ-1:0]   win,
   output logic               any
);

   rsbus_pri_t       pri_a [N_REQ];
   rsbus_pri_t       max_pri;
   logic             found;
   logic [PTR_W-1:0] idx;

   // Unpack per-requester priorities.
   always_comb begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
         pri_a[k] = pri[k*2 +: 2];
      end
   end

   // Find the top priority, then scan from rr_ptr for the first eligible at that level.
   always_comb begin
      max_pri = '0;
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (elig[k] && (pri_a[k] > max_pri)) begin
            max_pri = pri_a[k];
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((32'(rr_ptr) + i) % N_REQ);
         if (!found && elig[idx] && (pri_a[idx] == max_pri)) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |elig;

endmodule

// File: rtl/rsbus_slot_scheduler.sv
// Ring slot scheduler: inserts local requester frames into free ring slots,
// passing used slots through with one cycle of latency.
module rsbus_slot_scheduler
   import rsbus_slot_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned SHORT_WORDS = RSBUS_SHORT_WORDS,
   parameter int unsigned LONG_WORDS  = RSBUS_LONG_WORDS
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_sof,
   input  rbus_ctrl_t                           i_ctrl,
   input  rbus_word_t                           i_bus,
   output logic                                 o_sof,
   output rbus_ctrl_t                           o_ctrl,
   output rbus_word_t                           o_bus,
   input  logic [N_REQ-1:0]                     i_req,
   input  logic [N_REQ-1:0]                     i_req_long,
   input  logic [N_REQ*2-1:0]                   i_req_pri,
   input  logic [N_REQ*$bits(rbus_ctrl_t)-1:0]  i_req_ctrl,
   input  logic [N_REQ*$bits(rbus_word_t)-1:0]  i_req_bus,
   output logic [N_REQ-1:0]                     o_pop,
   output logic [N_REQ-1:0]                     o_grant,
   output logic                                 o_ovr_err
);

   localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W  = $clog2(LONG_WORDS + 1);
   localparam int unsigned WORD_W = $bits(rbus_word_t);
   localparam int unsigned CTRL_W = $bits(rbus_ctrl_t);
   localparam int unsigned HDR_W  = RSBUS_HDR_CTRL_W;

   sched_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   cur_q, cur_d;
   logic [PTR_W-1:0]   rr_q, rr_d;

   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   win_oh;
   logic               any;
   logic               grant;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   sel_idx;
   logic               fill_beat;
   logic               ovr;
   rbus_word_t         sel_word;
   rbus_ctrl_t         sel_ctrl;
   rbus_word_t         bus_d;
   rbus_ctrl_t         ctrl_d;

   logic                      sof_q;
   logic                      ctrl_valid_q;
   logic [CTRL_W-2:0]         ctrl_rest_q;
   logic [HDR_W-1:0]          hdr_q;
   logic [WORD_W-HDR_W-1:0]   data_q;

   // Eligibility: free slot header, requester ready, long frames only into long slots.
   always_comb begin
      elig = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         elig[k] = i_sof & ~i_bus.header.frm_used & i_req[k]
                 & (~i_req_long[k] | i_bus.header.frm_len);
      end
   end

   rsbus_rr_pri_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .elig   (elig),
      .pri    (i_req_pri),
      .rr_ptr (rr_q),
      .win    (win_oh),
      .any    (any)
   );

   assign grant     = any & ~rst;
   assign fill_beat = (state_q == ST_FILL) & ~i_sof;
   assign ovr       = (state_q == ST_FILL) & i_sof;
   assign sel_idx   = grant ? win_idx : cur_q;

   // Encode the one-hot winner and select the active requester's word.
   always_comb begin
      win_idx  = '0;
      sel_word = '0;
      sel_ctrl = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (win_oh[k]) begin
            win_idx = PTR_W'(k);
         end
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (PTR_W'(k) == sel_idx) begin
            sel_word = i_req_bus[k*WORD_W +: WORD_W];
            sel_ctrl = i_req_ctrl[k*CTRL_W +: CTRL_W];
         end
      end
   end

   // Handshake outputs; all held low while in reset.
   always_comb begin
      o_grant   = '0;
      o_pop     = '0;
      o_ovr_err = 1'b0;
      if (!rst) begin
         o_ovr_err = ovr;
         if (grant) begin
            o_grant = win_oh;
            o_pop   = win_oh;
         end else if (fill_beat) begin
            o_pop[cur_q] = 1'b1;
         end
      end
   end

   // Next ring word: stamped header on grant, requester data in FILL, ring data otherwise.
   always_comb begin
      bus_d  = i_bus;
      ctrl_d = i_ctrl;
      if (grant) begin
         bus_d                  = sel_word;
         bus_d.header.frm_used  = 1'b1;
         bus_d.header.frm_owned = 1'b1;
         bus_d.header.frm_len   = i_req_long[win_idx];
         ctrl_d                 = sel_ctrl;
         ctrl_d.valid           = 1'b1;
      end else if (fill_beat) begin
         bus_d  = sel_word;
         ctrl_d = sel_ctrl;
      end else if ((state_q == ST_PAD) && !i_sof) begin
         ctrl_d.valid = 1'b0;
      end
   end

   // FSM next state: every sof re-arbitrates, which also aborts an unfinished FILL.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      rr_d    = rr_q;
      if (grant) begin
         state_d = ST_FILL;
         cnt_d   = i_req_long[win_idx] ? CNT_W'(LONG_WORDS - 1) : CNT_W'(SHORT_WORDS - 1);
         cur_d   = win_idx;
         rr_d    = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (i_sof) begin
         state_d = ST_PASS;
      end else if (state_q == ST_FILL) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            state_d = ST_PAD;
         end
      end
   end

   // State, counter, current winner and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_PASS;
         cnt_q   <= '0;
         cur_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         rr_q    <= rr_d;
      end
   end

   // Control-bearing output flops: sof, valid and header control bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         sof_q        <= 1'b0;
         ctrl_valid_q <= 1'b0;
         hdr_q        <= '0;
      end else begin
         sof_q        <= i_sof;
         ctrl_valid_q <= ctrl_d.valid;
         hdr_q        <= bus_d[WORD_W-1 -: HDR_W];
      end
   end

   // Data-only output flops, no reset.
   always_ff @(posedge clk) begin
      ctrl_rest_q <= ctrl_d[CTRL_W-2:0];
      data_q      <= bus_d[WORD_W-HDR_W-1:0];
   end

   assign o_sof  = sof_q;
   assign o_ctrl = {ctrl_valid_q, ctrl_rest_q};
   assign o_bus  = {hdr_q, data_q};

endmodule

// File: tb/tb_rsbus_slot_scheduler.sv
// Self-checking bench for rsbus_slot_scheduler with a one-deep output scoreboard.
module tb_rsbus_slot_scheduler;
   import rsbus_slot_scheduler_pkg::*;

   localparam int N = 4;

   typedef struct packed {
      logic       sof;
      rbus_ctrl_t ctrl;
      rbus_word_t bus;
      logic       hdr_only;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_sof;
   rbus_ctrl_t        i_ctrl;
   rbus_word_t        i_bus;
   logic              o_sof;
   rbus_ctrl_t        o_ctrl;
   rbus_word_t        o_bus;
   logic [N-1:0]      i_req, i_req_long, o_pop, o_grant;
   logic [2*N-1:0]    i_req_pri;
   logic [N*4-1:0]    i_req_ctrl;
   logic [N*32-1:0]   i_req_bus;
   logic              o_ovr_err;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         seq [N];
   int         ptr [N];
   rsbus_pri_t pri_cfg [N];
   int         slot_no = 0;
   exp_t       sb [$];

   rsbus_slot_scheduler #(
      .N_REQ       (N),
      .SHORT_WORDS (2),
      .LONG_WORDS  (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_sof      (i_sof),
      .i_ctrl     (i_ctrl),
      .i_bus      (i_bus),
      .o_sof      (o_sof),
      .o_ctrl     (o_ctrl),
      .o_bus      (o_bus),
      .i_req      (i_req),
      .i_req_long (i_req_long),
      .i_req_pri  (i_req_pri),
      .i_req_ctrl (i_req_ctrl),
      .i_req_bus  (i_req_bus),
      .o_pop      (o_pop),
      .o_grant    (o_grant),
      .o_ovr_err  (o_ovr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v;
      v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   function automatic rbus_word_t req_word(input int k, input int s, input int j, input rsbus_pri_t p);
      rbus_word_t w;
      if (j == 0) begin
         w.header.frm_used     = 1'b0;
         w.header.frm_owned    = 1'b0;
         w.header.frm_priority = p;
         w.header.frm_len      = 1'b0;
         w.header.payload      = 27'((k << 20) | ((s & 255) << 8) | 8'h3C);
      end else begin
         w.raw = 32'hC000_0000 | 32'(k << 24) | 32'((s & 255) << 16) | 32'(j);
      end
      return w;
   endfunction

   function automatic rbus_ctrl_t req_ctrl(input int k);
      rbus_ctrl_t c;
      c.valid = 1'b1;
      c.tag   = 3'(k);
      return c;
   endfunction

   function automatic rbus_word_t ring_word(input int slot, input int i, input bit used, input bit lenb);
      rbus_word_t w;
      if (i == 0) begin
         w.header.frm_used     = used;
         w.header.frm_owned    = used;
         w.header.frm_priority = 2'b10;
         w.header.frm_len      = lenb;
         w.header.payload      = 27'(slot);
      end else begin
         w.raw = 32'h5000_0000 | 32'(slot << 8) | 32'(i);
      end
      return w;
   endfunction

   function automatic rbus_ctrl_t ring_ctrl(input int i);
      rbus_ctrl_t c;
      c.valid = 1'b1;
      c.tag   = 3'(i);
      return c;
   endfunction

   task automatic drive_reqs();
      for (int k = 0; k < N; k++) begin
         i_req_bus[k*32 +: 32] = req_word(k, seq[k], ptr[k], pri_cfg[k]);
         i_req_ctrl[k*4 +: 4]  = req_ctrl(k);
         i_req_pri[k*2 +: 2]   = pri_cfg[k];
      end
   endtask

   task automatic setup_reqs(input logic [N-1:0] req, input logic [N-1:0] lng,
                             input rsbus_pri_t p0, input rsbus_pri_t p1,
                             input rsbus_pri_t p2, input rsbus_pri_t p3);
      i_req      = req;
      i_req_long = lng;
      pri_cfg[0] = p0;
      pri_cfg[1] = p1;
      pri_cfg[2] = p2;
      pri_cfg[3] = p3;
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("o_sof", 64'(o_sof), 64'(e.sof));
         if (e.hdr_only) begin
            check("o_hdr_ctl", 64'({o_ctrl.valid, o_bus.raw[31:27]}),
                  64'({e.ctrl.valid, e.bus.raw[31:27]}));
         end else begin
            check("o_ctrl", 64'(o_ctrl), 64'(e.ctrl));
            check("o_bus", 64'(o_bus), 64'(e.bus));
         end
      end
   endtask

   // One clock: check handshake at the falling edge, registered outputs after the rising edge.
   task automatic step(input exp_t e, input logic [N-1:0] exp_grant,
                       input logic [N-1:0] exp_pop, input logic exp_ovr);
      logic [N-1:0] pop_s;
      sb.push_back(e);
      @(negedge clk);
      check("o_grant", 64'(o_grant), 64'(exp_grant));
      check("o_pop", 64'(o_pop), 64'(exp_pop));
      check("o_ovr_err", 64'(o_ovr_err), 64'(exp_ovr));
      pop_s = o_pop;
      @(posedge clk);
      #1;
      compare_out();
      for (int k = 0; k < N; k++) begin
         if (pop_s[k]) ptr[k]++;
      end
   endtask

   // Drive one ring slot; w is the expected winner (-1 = none).
   task automatic run_slot(input int period, input bit used, input bit lenb, input int w,
                           input bit wlong, input bit ovr, input int ncyc);
      exp_t e;
      int   flen;
      flen = wlong ? 10 : 2;
      for (int i = 0; i < ncyc; i++) begin
         i_sof  = (i == 0);
         i_bus  = ring_word(slot_no, i, used, lenb);
         i_ctrl = ring_ctrl(i);
         drive_reqs();
         e.sof      = (i == 0);
         e.hdr_only = 1'b0;
         if (w >= 0 && i < flen && i < period) begin
            e.bus  = req_word(w, seq[w], i, pri_cfg[w]);
            e.ctrl = req_ctrl(w);
            if (i == 0) begin
               e.bus.header.frm_used  = 1'b1;
               e.bus.header.frm_owned = 1'b1;
               e.bus.header.frm_len   = wlong;
               e.ctrl.valid           = 1'b1;
            end
         end else begin
            e.bus  = i_bus;
            e.ctrl = i_ctrl;
            if (w >= 0) e.ctrl.valid = 1'b0;
         end
         step(e, (i == 0) ? onehot(w) : '0,
              (w >= 0 && i < flen) ? onehot(w) : '0,
              (i == 0) && ovr);
      end
      slot_no++;
      if (w >= 0) begin
         seq[w]++;
         ptr[w] = 0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      for (int k = 0; k < N; k++) begin
         seq[k] = k * 16;
         ptr[k] = 0;
      end
      rst    = 1'b1;
      i_sof  = 1'b0;
      i_bus  = ring_word(0, 1, 1'b0, 1'b0);
      i_ctrl = ring_ctrl(1);
      setup_reqs(4'b0000, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
      drive_reqs();

      // Reset state.
      e          = '0;
      e.hdr_only = 1'b1;
      repeat (3) step(e, '0, '0, 1'b0);
      rst = 1'b0;

      // Free long slots, nobody requesting: pure one-cycle pass-through.
      run_slot(12, 1'b0, 1'b1, -1, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b1, -1, 1'b0, 1'b0, 12);

      // Equal priority short frames alternate round-robin.
      setup_reqs(4'b0011, 4'b0000, 2'd1, 2'd1, 2'd0, 2'd0);
      run_slot(12, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b0, 1, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b0, 1, 1'b0, 1'b0, 12);

      // Long frame cannot take a short slot; the short one wins it.
      setup_reqs(4'b1100, 4'b0100, 2'd0, 2'd0, 2'd0, 2'd3);
      run_slot(12, 1'b0, 1'b0, 3, 1'b0, 1'b0, 12);
      setup_reqs(4'b0100, 4'b0100, 2'd0, 2'd0, 2'd0, 2'd3);
      run_slot(12, 1'b0, 1'b0, -1, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b1, 2, 1'b1, 1'b0, 12);

      // Used slot passes untouched even with every requester ready.
      setup_reqs(4'b1111, 4'b0101, 2'd3, 2'd3, 2'd3, 2'd3);
      run_slot(12, 1'b1, 1'b1, -1, 1'b0, 1'b0, 12);

      // Round-robin pointer sits at 3: tie between 0 and 3 goes to 3, then priority beats rr.
      setup_reqs(4'b1011, 4'b0000, 2'd2, 2'd1, 2'd0, 2'd2);
      run_slot(12, 1'b0, 1'b0, 3, 1'b0, 1'b0, 12);
      setup_reqs(4'b1011, 4'b0000, 2'd2, 2'd3, 2'd0, 2'd2);
      run_slot(12, 1'b0, 1'b0, 1, 1'b0, 1'b0, 12);

      // Slot too short for a long frame: overrun on the next sof, which is still arbitrated.
      setup_reqs(4'b0100, 4'b0100, 2'd0, 2'd0, 2'd1, 2'd0);
      run_slot(6, 1'b0, 1'b1, 2, 1'b1, 1'b0, 6);
      setup_reqs(4'b0010, 4'b0000, 2'd0, 2'd2, 2'd0, 2'd0);
      run_slot(12, 1'b0, 1'b0, 1, 1'b0, 1'b1, 12);

      // Reset during the 4th FILL beat aborts the insertion.
      setup_reqs(4'b0001, 4'b0001, 2'd0, 2'd0, 2'd0, 2'd0);
      run_slot(12, 1'b0, 1'b1, 0, 1'b1, 1'b0, 4);
      i_sof  = 1'b0;
      i_bus  = ring_word(slot_no, 4, 1'b0, 1'b1);
      i_ctrl = ring_ctrl(4);
      rst    = 1'b1;
      drive_reqs();
      e          = '0;
      e.hdr_only = 1'b1;
      step(e, '0, '0, 1'b0);
      rst    = 1'b0;
      i_bus  = ring_word(slot_no, 5, 1'b0, 1'b1);
      i_ctrl = ring_ctrl(5);
      drive_reqs();
      e.sof      = 1'b0;
      e.hdr_only = 1'b0;
      e.bus      = i_bus;
      e.ctrl     = i_ctrl;
      step(e, '0, '0, 1'b0);
      slot_no++;

      // Pointer back at 0: short frames on long slots, 0 then 1.
      setup_reqs(4'b0011, 4'b0000, 2'd1, 2'd1, 2'd0, 2'd0);
      run_slot(12, 1'b0, 1'b1, 0, 1'b0, 1'b0, 12);
      run_slot(12, 1'b0, 1'b1, 1, 1'b0, 1'b0, 12);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
